// File: rtl/rand_mm_master.sv
// Random-word Avalon-MM master.
// Repeatedly reads a 32-bit word from a fixed-latency slave at address 0 and
// buffers the words in a small FIFO for a valid/ready consumer. A pending
// seed request preempts reads and is written to the same slave address.
module rand_mm_master #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEVEL_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [1:0]         avm_address,
  output logic               avm_read,
  input  logic [31:0]        avm_readdata,
  output logic               avm_write,
  output logic [31:0]        avm_writedata,
  input  logic               seed_valid,
  input  logic [31:0]        seed_data,
  output logic               seed_ready,
  output logic               out_valid,
  output logic [31:0]        out_data,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE
  } state_e;

  state_e             state_q, state_d;
  logic               read_q, write_q, seed_ready_q;
  logic [31:0]        wdata_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LEVEL_W-1:0] level_q;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic               push, pop;

  // Next-state decode: seed wins over reads, reads only when there is room.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (seed_valid)                           state_d = S_WRITE;
        else if (enable && (level_q < FULL_LEVEL)) state_d = S_READ;
      end
      S_WRITE:   state_d = S_IDLE;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register and registered decode of the bus strobes.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      seed_ready_q <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= (state_d == S_READ);
      write_q      <= (state_d == S_WRITE);
      seed_ready_q <= (state_d == S_WRITE);
      if ((state_q == S_IDLE) && (state_d == S_WRITE)) wdata_q <= seed_data;
    end
  end

  // The read data is valid in the cycle after the strobe, i.e. in CAPTURE.
  assign push = (state_q == S_CAPTURE);
  assign pop  = out_valid && out_ready;

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage written on every capture.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; occupancy gates every read, so stale contents are never visible.
    if (push) mem_q[wr_ptr_q] <= avm_readdata;
  end

  assign avm_address   = 2'b00;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign seed_ready    = seed_ready_q;
  assign fifo_level    = level_q;
  assign out_valid     = (level_q != '0);
  assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_rand_mm_master.sv
// Self-checking bench for rand_mm_master: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (a queue of captured words plus the bus phase).
module tb_rand_mm_master;

  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          seed_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   seed_data = '0;
  logic [31:0]   avm_readdata = '0;
  logic [1:0]    avm_address;
  logic          avm_read, avm_write, seed_ready, out_valid;
  logic [31:0]   avm_writedata, out_data;
  logic [LW-1:0] fifo_level;

  rand_mm_master #(.FIFO_DEPTH(DEPTH), .LEVEL_W(LW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave with read latency 1: 0 = counting 1,2,3..., 1 = random, 2 = fixed word.
  int          slave_sel = 0;
  logic [31:0] slave_fixed = '0;
  int unsigned slave_cnt = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) slave_cnt <= 0;
    else if (avm_read) begin
      case (slave_sel)
        0:       avm_readdata <= slave_cnt + 1;
        1:       avm_readdata <= $urandom;
        default: avm_readdata <= slave_fixed;
      endcase
      slave_cnt <= slave_cnt + 1;
    end else begin
      avm_readdata <= $urandom;
    end
  end

  // Reference model: m_* describe what the bus shows in the current cycle,
  // mq holds the buffered words oldest first.
  logic [31:0] mq[$];
  bit          m_read = 0, m_write = 0, m_cap = 0;
  logic [31:0] m_wdata = '0;
  always @(posedge clk or posedge reset) begin : model
    bit n_read, n_write, n_cap;
    if (reset) begin
      mq.delete();
      m_read = 0; m_write = 0; m_cap = 0; m_wdata = '0;
    end else begin
      n_read = 0; n_write = 0; n_cap = 0;
      if (m_read) n_cap = 1;
      else if (!m_cap && !m_write) begin
        if (seed_valid) begin
          n_write = 1;
          m_wdata = seed_data;
        end else if (enable && mq.size() < DEPTH) begin
          n_read = 1;
        end
      end
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (m_cap) mq.push_back(avm_readdata);
      m_read = n_read; m_write = n_write; m_cap = n_cap;
    end
  end

  int rd_stamps[$];
  bit cafe_seen = 0;

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("avm_read", avm_read, m_read);
      check("avm_write", avm_write, m_write);
      check("avm_address", avm_address, 0);
      check("seed_ready", seed_ready, m_write);
      check("rd_wr_exclusive", avm_read & avm_write, 0);
      if (m_write || reset) check("avm_writedata", avm_writedata, m_wdata);
      check("fifo_level", fifo_level, 32'(mq.size()));
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("out_data", out_data, mq[0]);
      else if (reset) check("out_data_reset", out_data, 0);
      if (avm_read) rd_stamps.push_back(cyc);
      if (out_valid && out_data == 32'hCAFEF00D) cafe_seen = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wait_read(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!avm_read && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!avm_read) begin
      fails++;
      $display("FAIL %s: no avm_read within 50 cycles, got 0 expected 1", tag);
    end
  endtask

  task automatic drain_expect(input string tag, input int first, input int last);
    step();
    out_ready = 1'b1;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      check({tag, "_data"}, out_data, i);
      check({tag, "_valid"}, out_valid, 1);
      step();
    end
    @(negedge clk);
    check({tag, "_valid_end"}, out_valid, 0);
    check({tag, "_level_end"}, fifo_level, 0);
  endtask

  initial begin
    int base;
    fork
      compare_loop();
    join_none

    // Reset held for three cycles: every output at zero.
    #1 reset = 1'b1;
    steps(3);
    @(negedge clk);
    check("rst_read", avm_read, 0);
    check("rst_write", avm_write, 0);
    check("rst_address", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_seed_ready", seed_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_level", fifo_level, 0);

    // Fill: eight reads three cycles apart, then no more.
    step();
    reset = 1'b0;
    enable = 1'b1;
    out_ready = 1'b0;
    base = rd_stamps.size();
    steps(40);
    @(negedge clk);
    check("fill_reads", rd_stamps.size() - base, 8);
    for (int i = base + 1; i < rd_stamps.size(); i++)
      check("fill_gap", rd_stamps[i] - rd_stamps[i-1], 3);
    check("fill_level", fifo_level, 8);

    // Drain: 1..8 on consecutive cycles.
    step();
    enable = 1'b0;
    drain_expect("drain", 1, 8);

    // Full push/pop with wrapped pointers.
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    enable = 1'b1;
    steps(40);
    @(negedge clk);
    check("pp_full", fifo_level, 8);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_level7", fifo_level, 7);
    wait_read("pp_read");
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("pp_level_kept", fifo_level, 7);
    check("pp_head", out_data, 3);
    drain_expect("pp_drain", 3, 9);

    // Seed arriving mid-read: read completes, then a single write cycle.
    step();
    enable = 1'b1;
    wait_read("seed_read");
    seed_data = 32'hDEADBEEF;
    seed_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("seed_not_early", avm_write, 0);
    @(negedge clk);
    check("seed_write", avm_write, 1);
    check("seed_ready_pulse", seed_ready, 1);
    check("seed_no_read", avm_read, 0);
    check("seed_address", avm_address, 0);
    check("seed_wdata", avm_writedata, 32'hDEADBEEF);
    step();
    seed_valid = 1'b0;
    enable = 1'b0;

    // Reset during CAPTURE discards the in-flight word.
    steps(3);
    slave_sel = 2;
    slave_fixed = 32'hCAFEF00D;
    out_ready = 1'b1;
    enable = 1'b1;
    wait_read("mid_rst_read");
    step();
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    enable = 1'b0;
    steps(5);
    @(negedge clk);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_no_cafe", cafe_seen, 0);

    // Randomized traffic against the model.
    slave_sel = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      enable = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) != 0;
      if (seed_valid && seed_ready) seed_valid = 1'b0;
      else if (!seed_valid && $urandom_range(0, 19) == 0) begin
        seed_valid = 1'b1;
        seed_data = $urandom;
      end
    end
    reset = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
